etpu_wb_host: RTL and testbench

- Wishbone classic *initiator* that runs one complete edu_tpu job: weight load, input streaming, result readback.
- Pulls 32-bit job words from a valid/ready source stream, issues the single-beat bus writes and reads at BASE_ADDRESS, and returns result words on a valid/ready sink.
- Sits between a test/host controller (or management-core stand-in) and the TPU's Wishbone target.

---
 rtl/etpu_wb_host.sv | 183 ++++++++++++++++++
 tb/tb_etpu_wb_host.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/etpu_wb_host.sv
// Wishbone classic initiator that runs one edu_tpu job from a job-word stream:
// weight writes, input writes, a compute wait, then result reads to a sink.
module etpu_wb_host #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int unsigned N_WEIGHT     = 4,
    parameter int unsigned N_INPUT      = 11,
    parameter int unsigned N_RESULT     = 5,
    parameter int unsigned RUN_GAP      = 40,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [31:0] r_data,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WR, S_GAP, S_WAIT, S_RD, S_PUSH, S_DONE, S_ERR
    } state_t;

    typedef enum logic [1:0] {PH_WEIGHT, PH_INPUT, PH_READ} phase_t;

    localparam logic [3:0] LAST_W   = 4'(N_WEIGHT - 1);
    localparam logic [3:0] LAST_I   = 4'(N_INPUT - 1);
    localparam logic [3:0] LAST_R   = 4'(N_RESULT - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] RUN_LAST = 8'(RUN_GAP - 1);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= PH_WEIGHT;
            cnt_q   <= '0;
            tmo_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    // tmo_q doubles as the WAIT-phase cycle counter; it idles at zero elsewhere.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        tmo_d   = '0;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    phase_d = PH_WEIGHT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (s_valid) begin
                    wdat_d  = s_data;
                    state_d = S_WR;
                end
            end
            S_WR, S_RD: begin
                if (wbm_ack_i) begin
                    state_d = (state_q == S_WR) ? S_GAP : S_PUSH;
                    if (state_q == S_RD) begin
                        rdat_d = (cnt_q == LAST_R) ? {16'h0, wbm_dat_i[15:0]}
                                                   : wbm_dat_i;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_GAP: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = S_FETCH;
                case (phase_q)
                    PH_WEIGHT: begin
                        if (cnt_q == LAST_W) begin
                            phase_d = PH_INPUT;
                            cnt_d   = '0;
                        end
                    end
                    PH_INPUT: begin
                        if (cnt_q == LAST_I) begin
                            phase_d = PH_READ;
                            cnt_d   = '0;
                            state_d = S_WAIT;
                        end
                    end
                    default: state_d = (cnt_q == LAST_R) ? S_DONE : S_RD;
                endcase
            end
            S_WAIT: begin
                if (tmo_q == RUN_LAST) state_d = S_RD;
                else tmo_d = tmo_q + 8'd1;
            end
            S_PUSH: begin
                if (r_ready) state_d = S_GAP;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        s_ready   = 1'b0;
        r_valid   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            S_WR: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                busy      = 1'b1;
            end
            S_RD: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                busy      = 1'b1;
            end
            S_PUSH: begin
                r_valid = 1'b1;
                busy    = 1'b1;
            end
            S_GAP, S_WAIT: busy = 1'b1;
            S_DONE:        done = 1'b1;
            default: ;
        endcase
    end

    assign wbm_sel_o = 4'hF;
    assign wbm_adr_o = BASE_ADDRESS;
    assign wbm_dat_o = wdat_q;
    assign r_data    = rdat_q;
    assign err       = err_q;

endmodule

// File: tb/tb_etpu_wb_host.sv
// Directed bench for etpu_wb_host: job-word source, Wishbone target model and
// result sink driven on the falling edge; bus and result traffic checked.
module tb_etpu_wb_host;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        r_valid;
    logic        r_ready = 1'b1;
    logic [31:0] r_data;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i;
    logic        ack_q = 1'b0;

    etpu_wb_host dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .err(err), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ack_mode = 0;
    bit src_en = 0;
    bit src_toggle = 0;
    int stall_idx = -1;
    int clr_gen = 0;
    logic [31:0] src_words [15];
    logic [31:0] rd_words [5];
    logic [31:0] exp_res [5];

    int seen_gen = 0, cyc_n = 0, stb_age = 0, src_idx = 0, rd_idx = 0;
    int n_wr = 0, n_res = 0, done_cnt = 0, bad_bus = 0, viol = 0;
    int unstable = 0, idle_gap = 0, st_cnt = 0, tmo_stb = 0;
    bit rd_started = 0, was_stall = 0;
    logic [31:0] held = '0;
    logic [31:0] wr_q [$];
    logic [31:0] res_q [$];

    assign wbm_ack_i = (ack_mode == 1) ? (wbm_cyc_o & wbm_stb_o) : ack_q;

    always @(negedge clk) begin
        bit ack_now;
        if (clr_gen != seen_gen) begin
            seen_gen = clr_gen;
            src_idx = 0; rd_idx = 0; n_wr = 0; n_res = 0; done_cnt = 0;
            bad_bus = 0; viol = 0; unstable = 0; idle_gap = 0; st_cnt = 0;
            tmo_stb = 0; rd_started = 0; was_stall = 0; stb_age = 0;
            wr_q.delete();
            res_q.delete();
        end
        cyc_n++;
        wbm_dat_i = (rd_idx < 5) ? rd_words[rd_idx] : '0;
        if (wbm_cyc_o && wbm_stb_o) begin
            ack_q = (stb_age >= 1) && !ack_q &&
                    !(ack_mode == 2 && wbm_we_o && n_wr == 2);
            stb_age++;
        end else begin
            ack_q = 1'b0;
            stb_age = 0;
        end
        ack_now = (ack_mode == 1) ? (wbm_cyc_o && wbm_stb_o) : ack_q;
        if (wbm_stb_o && wbm_we_o && n_wr == 2) tmo_stb++;
        if (wbm_stb_o && !wbm_we_o) rd_started = 1;
        if (!wbm_stb_o && n_wr == 15 && !rd_started) idle_gap++;
        if (wbm_cyc_o && wbm_stb_o && ack_now) begin
            if (wbm_we_o) begin
                wr_q.push_back(wbm_dat_o);
                n_wr++;
                if (wbm_adr_o != BASE || wbm_sel_o != 4'hF) bad_bus++;
            end else begin
                rd_idx++;
            end
        end
        if (wbm_stb_o && (s_ready || r_valid)) viol++;
        s_valid = src_en && src_idx < 15 && (!src_toggle || cyc_n[0]);
        s_data = s_valid ? src_words[src_idx] : '0;
        if (s_valid && s_ready) src_idx++;
        if (r_valid && n_res == stall_idx && st_cnt < 10) begin
            r_ready = 1'b0;
            st_cnt++;
        end else begin
            r_ready = 1'b1;
        end
        if (r_valid && !r_ready) begin
            if (was_stall && r_data != held) unstable++;
            held = r_data;
            was_stall = 1;
        end else begin
            was_stall = 0;
        end
        if (r_valid && r_ready) begin
            res_q.push_back(r_data);
            n_res++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_tb();
        clr_gen++;
        @(negedge clk);
    endtask

    task automatic start_job(input bit chk_lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (chk_lat) begin
            check("lat_busy", busy, 1);
            check("lat_stb1", wbm_stb_o, 0);
            @(posedge clk);
            #1;
            check("lat_stb2", wbm_stb_o, 1);
        end
    endtask

    task automatic wait_end(input string tag, input bit want_err);
        int n = 0;
        while (n < 3000 && !(want_err ? err : (done_cnt > 0))) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, n < 3000, 1);
    endtask

    task automatic check_job(input string tag);
        int bad = 0;
        check({tag, "_writes"}, n_wr, 15);
        for (int i = 0; i < wr_q.size() && i < 15; i++)
            if (wr_q[i] !== src_words[i]) bad++;
        check({tag, "_wdata"}, bad, 0);
        check({tag, "_bus"}, bad_bus, 0);
        check({tag, "_nres"}, n_res, 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s_res%0d", tag, i),
                  (res_q.size() > i) ? res_q[i] : 32'hFFFF_FFFF, exp_res[i]);
        check({tag, "_done"}, done_cnt, 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) src_words[i] = 32'h0101_0101 * (i + 1);
        for (int i = 4; i < 15; i++) src_words[i] = 32'h0001_0203;
        rd_words[0] = 32'h1111_2222; rd_words[1] = 32'h3333_4444;
        rd_words[2] = 32'h5555_6666; rd_words[3] = 32'h7777_8888;
        rd_words[4] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) exp_res[i] = rd_words[i];
        exp_res[4] = 32'h0000_BEEF;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_srdy", s_ready, 0);
        check("rst_rvld", r_valid, 0);
        check("rst_dat", wbm_dat_o, 0);
        check("rst_rdata", r_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // nominal job with latency and compute-wait checks
        clear_tb();
        src_en = 1;
        start_job(1);
        wait_end("nom_end", 0);
        repeat (3) @(negedge clk);
        check_job("nom");
        check("nom_gap", idle_gap, 41);
        check("nom_busy", busy, 0);
        check("nom_err", err, 0);

        // source/sink backpressure, plus a start while busy
        clear_tb();
        src_toggle = 1;
        stall_idx = 2;
        start_job(0);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("bp_end", 0);
        repeat (3) @(negedge clk);
        check_job("bp");
        check("bp_stall", st_cnt, 10);
        check("bp_stable", unstable, 0);
        check("bp_viol", viol, 0);

        // target holds ack for as long as strobe is high
        clear_tb();
        src_toggle = 0;
        stall_idx = -1;
        ack_mode = 1;
        start_job(0);
        wait_end("sg_end", 0);
        repeat (3) @(negedge clk);
        check_job("sg");

        // third weight write never acked
        clear_tb();
        ack_mode = 2;
        start_job(0);
        wait_end("to_end", 1);
        check("to_cyc", wbm_cyc_o, 0);
        check("to_stb", wbm_stb_o, 0);
        check("to_busy", busy, 0);
        check("to_err", err, 1);
        check("to_len", tmo_stb, 255);
        check("to_nwr", n_wr, 2);
        ack_mode = 0;
        clear_tb();
        start_job(0);
        check("to_errclr", err, 0);
        wait_end("to2_end", 0);
        repeat (3) @(negedge clk);
        check_job("to2");

        // async reset in the first cycle of the sixth write
        clear_tb();
        start_job(0);
        n = 0;
        while (!(n_wr == 5 && wbm_stb_o) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ar_reach", n < 2000, 1);
        rst = 1'b1;
        #1;
        check("ar_cyc", wbm_cyc_o, 0);
        check("ar_stb", wbm_stb_o, 0);
        check("ar_busy", busy, 0);
        src_en = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ar_idle", busy, 0);
        clear_tb();
        src_en = 1;
        start_job(1);
        wait_end("ar_end", 0);
        repeat (3) @(negedge clk);
        check_job("ar");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
